// File: rtl/digit_scan_mux.sv
// Time-multiplexed driver for four hex digits. New values are staged as pending
// and only become active at a frame boundary, so a frame never shows a mix of values.
module digit_scan_mux #(
   parameter int PRESCALE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] value,
   input  logic        blank_lz,
   output logic [3:0]  data,
   output logic [3:0]  an,
   output logic        load_ack,
   output logic        frame
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [15:0]   act_val;
   logic          act_blank;
   logic [15:0]   pend_val;
   logic          pend_blank;
   logic          pend_valid;

   logic tick;
   logic boundary;

   assign tick     = (cnt == LAST);
   assign boundary = tick && (idx == 2'd3);

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt        <= '0;
         idx        <= 2'd0;
         act_val    <= 16'h0;
         act_blank  <= 1'b0;
         pend_val   <= 16'h0;
         pend_blank <= 1'b0;
         pend_valid <= 1'b0;
         load_ack   <= 1'b0;
         frame      <= 1'b0;
      end else begin
         cnt      <= tick ? '0 : cnt + 1'b1;
         if (tick)
            idx <= idx + 2'd1;
         frame    <= boundary;
         load_ack <= boundary && (load || pend_valid);
         if (boundary) begin
            // A load landing on the boundary itself wins over anything pending.
            if (load) begin
               act_val   <= value;
               act_blank <= blank_lz;
            end else if (pend_valid) begin
               act_val   <= pend_val;
               act_blank <= pend_blank;
            end
            pend_valid <= 1'b0;
         end else if (load) begin
            pend_val   <= value;
            pend_blank <= blank_lz;
            pend_valid <= 1'b1;
         end
      end
   end

   // Leading-zero detection: digit i is blankable when digits i..3 are all zero.
   logic z3, z2, z1;
   logic blanked;

   assign z3 = (act_val[15:12] == 4'h0);
   assign z2 = z3 && (act_val[11:8] == 4'h0);
   assign z1 = z2 && (act_val[7:4] == 4'h0);

   always_comb begin
      blanked = 1'b0;
      case (idx)
         2'd1:    blanked = act_blank && z1;
         2'd2:    blanked = act_blank && z2;
         2'd3:    blanked = act_blank && z3;
         default: blanked = 1'b0;
      endcase
   end

   assign data = act_val[{idx, 2'b00} +: 4];
   assign an   = blanked ? 4'b1111 : ~(4'b0001 << idx);

endmodule

// File: tb/tb_digit_scan_mux.sv
// Scoreboard bench for digit_scan_mux: a cycle-count based reference model
// pushes expected outputs per clock; a negedge monitor pops and compares.
module tb_digit_scan_mux;

   localparam int P  = 4;
   localparam int FR = 4 * P;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load = 1'b0;
   logic [15:0] value = 16'h0;
   logic        blank_lz = 1'b0;
   logic [3:0]  data;
   logic [3:0]  an;
   logic        load_ack;
   logic        frame;

   digit_scan_mux #(.PRESCALE(P)) dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .value    (value),
      .blank_lz (blank_lz),
      .data     (data),
      .an       (an),
      .load_ack (load_ack),
      .frame    (frame)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] data;
      logic [3:0] an;
      logic       ack;
      logic       frame;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;

   // Reference model: display position derives purely from cycles since reset.
   int          m_cyc = 0;
   logic [15:0] m_act = 16'h0;
   logic        m_ablank = 1'b0;
   logic [15:0] m_pval = 16'h0;
   logic        m_pblank = 1'b0;
   logic        m_pv = 1'b0;

   task automatic model(input logic r, input logic l, input logic [15:0] v, input logic b);
      exp_t e;
      int   dig;
      bit   bnd, blk;
      e.ack   = 1'b0;
      e.frame = 1'b0;
      if (!r) begin
         m_cyc = 0; m_act = 16'h0; m_ablank = 1'b0;
         m_pval = 16'h0; m_pblank = 1'b0; m_pv = 1'b0;
      end else begin
         bnd = ((m_cyc % FR) == FR - 1);
         e.frame = bnd;
         if (bnd) begin
            if (l) begin
               m_act = v; m_ablank = b; e.ack = 1'b1;
            end else if (m_pv) begin
               m_act = m_pval; m_ablank = m_pblank; e.ack = 1'b1;
            end
            m_pv = 1'b0;
         end else if (l) begin
            m_pval = v; m_pblank = b; m_pv = 1'b1;
         end
         m_cyc++;
      end
      dig    = (m_cyc / P) % 4;
      e.data = 4'((m_act >> (4 * dig)) & 16'hF);
      blk    = m_ablank && (dig > 0) && ((m_act >> (4 * dig)) == 16'h0);
      e.an   = blk ? 4'b1111 : 4'(~(32'd1 << dig));
      exp_q.push_back(e);
   endtask

   task automatic step(input logic r, input logic l, input logic [15:0] v, input logic b);
      reset = r; load = l; value = v; blank_lz = b;
      @(posedge clk);
      model(r, l, v, b);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b0, 16'h0, 1'b0);
   endtask

   // Idle until the cycle about to be clocked sits at frame phase ph.
   task automatic to_phase(input int ph);
      for (int k = 0; k < 2 * FR && (m_cyc % FR) != ph; k++) idle(1);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("data", data, e.data);
         chk("an", an, e.an);
         chk("load_ack", load_ack, e.ack);
         chk("frame", frame, e.frame);
      end
   end

   initial begin
      #1;
      step(1'b0, 1'b0, 16'h0, 1'b0);
      step(1'b0, 1'b1, 16'h5555, 1'b1);
      // Free run
      idle(40);
      // Mid-frame load while idx=1
      to_phase(5);
      step(1'b1, 1'b1, 16'h12AB, 1'b0);
      idle(FR + 4);
      // Overwrite within one frame
      to_phase(2);
      step(1'b1, 1'b1, 16'h1111, 1'b0);
      idle(3);
      step(1'b1, 1'b1, 16'h2222, 1'b0);
      idle(FR + 4);
      // Blanking cases
      to_phase(1);
      step(1'b1, 1'b1, 16'h0005, 1'b1);
      idle(FR + 4);
      to_phase(1);
      step(1'b1, 1'b1, 16'h0000, 1'b1);
      idle(FR + 4);
      to_phase(1);
      step(1'b1, 1'b1, 16'h0100, 1'b1);
      idle(FR + 4);
      // Load exactly on the boundary, with a stale pending value queued
      to_phase(3);
      step(1'b1, 1'b1, 16'h7777, 1'b0);
      to_phase(FR - 1);
      step(1'b1, 1'b1, 16'hBEEF, 1'b0);
      idle(FR + 2);
      // Reset discards pending value
      to_phase(3);
      step(1'b1, 1'b1, 16'hCAFE, 1'b0);
      idle(2);
      step(1'b0, 1'b0, 16'h0, 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b0);
      idle(2 * FR + 4);
      // Randomized traffic
      for (int k = 0; k < 600; k++) begin
         logic r, l, b;
         logic [15:0] v;
         r = ($urandom_range(0, 149) != 0);
         l = ($urandom_range(0, 6) == 0);
         b = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0:       v = 16'($urandom_range(0, 15));
            1:       v = 16'($urandom_range(0, 255));
            2:       v = 16'($urandom_range(0, 4095));
            default: v = 16'($urandom);
         endcase
         step(r, l, v, b);
      end
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
